// File: rtl/decode_stage.sv
// Decode stage: turns 16-bit instruction words (one or two per instruction) into registered operands and control for execute.
// Latency 1 cycle from the accepted word (from the immediate for two-word ops); stall freezes every output and the FSM state.
// Backpressure: instr_ready = !stall. Register file writes proceed even while stalled.
module decode_stage #(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic [15:0] Op1,
    output logic [15:0] Op2,
    output logic [1:0]  ALUmode,
    output logic [1:0]  carrySelect,
    output logic [2:0]  Rdst_out,
    output logic        wb_en_out,
    output logic        valid_out
);
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_SETC = 5'd1;
    localparam logic [4:0] OP_CLRC = 5'd2;
    localparam logic [4:0] OP_NOT  = 5'd3;
    localparam logic [4:0] OP_MOV  = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_IADD = 5'd6;
    localparam logic [4:0] OP_LDM  = 5'd7;

    typedef enum logic {ST_OPCODE, ST_IMM} state_t;

    state_t      state_q, state_d;
    logic [4:0]  lat_op_q, lat_op_d;
    logic [2:0]  lat_rdst_q, lat_rdst_d;
    logic [2:0]  lat_rs1_q, lat_rs1_d;
    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] regs_d [NUM_REGS];
    logic [15:0] op1_q, op1_d, op2_q, op2_d;
    logic [1:0]  alu_q, alu_d, cs_q, cs_d;
    logic [2:0]  rdst_q, rdst_d;
    logic        wbo_q, wbo_d, vld_q, vld_d;

    logic        emit;
    logic [4:0]  dec_op;
    logic [2:0]  dec_rdst, dec_rs1, dec_rs2;
    logic [15:0] dec_imm;
    logic        unused_bits;

    assign unused_bits = ^instr[1:0];
    assign instr_ready = !stall;

    // Reads see a same-cycle writeback so back-to-back dependent ops need no extra bubble.
    function automatic logic [15:0] rf_read(input logic [2:0] a);
        return (wb_en && wb_addr == a) ? wb_data : regs_q[a];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wb_en) regs_d[wb_addr] = wb_data;
    end

    always_comb begin
        state_d    = state_q;
        lat_op_d   = lat_op_q;
        lat_rdst_d = lat_rdst_q;
        lat_rs1_d  = lat_rs1_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rdst_d     = rdst_q;
        alu_d      = 2'b11;
        cs_d       = 2'b00;
        wbo_d      = 1'b0;
        vld_d      = 1'b0;
        emit       = 1'b0;
        dec_op     = instr[15:11];
        dec_rdst   = instr[10:8];
        dec_rs1    = instr[7:5];
        dec_rs2    = instr[4:2];
        dec_imm    = 16'h0000;

        if (stall) begin
            alu_d = alu_q;
            cs_d  = cs_q;
            wbo_d = wbo_q;
            vld_d = vld_q;
        end else if (instr_valid) begin
            if (state_q == ST_IMM) begin
                state_d  = ST_OPCODE;
                dec_op   = lat_op_q;
                dec_rdst = lat_rdst_q;
                dec_rs1  = lat_rs1_q;
                dec_imm  = instr;
                emit     = 1'b1;
            end else if (instr[15:11] == OP_IADD || instr[15:11] == OP_LDM) begin
                state_d    = ST_IMM;
                lat_op_d   = instr[15:11];
                lat_rdst_d = instr[10:8];
                lat_rs1_d  = instr[7:5];
            end else begin
                emit = 1'b1;
            end
        end

        if (emit) begin
            vld_d  = 1'b1;
            rdst_d = dec_rdst;
            op1_d  = 16'h0000;
            op2_d  = 16'h0000;
            case (dec_op)
                OP_SETC: cs_d = 2'b01;
                OP_CLRC: cs_d = 2'b11;
                OP_NOT: begin
                    op1_d = rf_read(dec_rdst);
                    alu_d = 2'b01;
                    wbo_d = 1'b1;
                end
                OP_MOV: begin
                    op1_d = rf_read(dec_rs1);
                    alu_d = 2'b10;
                    wbo_d = 1'b1;
                end
                OP_ADD: begin
                    op1_d = rf_read(dec_rs1);
                    op2_d = rf_read(dec_rs2);
                    alu_d = 2'b00;
                    cs_d  = 2'b10;
                    wbo_d = 1'b1;
                end
                OP_IADD: begin
                    op1_d = rf_read(dec_rs1);
                    op2_d = dec_imm;
                    alu_d = 2'b00;
                    cs_d  = 2'b10;
                    wbo_d = 1'b1;
                end
                OP_LDM: begin
                    op1_d = dec_imm;
                    alu_d = 2'b10;
                    wbo_d = 1'b1;
                end
                default: ;  // OP_NOP and undefined opcodes
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OPCODE;
            lat_op_q   <= OP_NOP;
            lat_rdst_q <= 3'd0;
            lat_rs1_q  <= 3'd0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0000;
            op1_q      <= 16'h0000;
            op2_q      <= 16'h0000;
            alu_q      <= 2'b11;
            cs_q       <= 2'b00;
            rdst_q     <= 3'd0;
            wbo_q      <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_op_q   <= lat_op_d;
            lat_rdst_q <= lat_rdst_d;
            lat_rs1_q  <= lat_rs1_d;
            regs_q     <= regs_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            alu_q      <= alu_d;
            cs_q       <= cs_d;
            rdst_q     <= rdst_d;
            wbo_q      <= wbo_d;
            vld_q      <= vld_d;
        end
    end

    assign Op1         = op1_q;
    assign Op2         = op2_q;
    assign ALUmode     = alu_q;
    assign carrySelect = cs_q;
    assign Rdst_out    = rdst_q;
    assign wb_en_out   = wbo_q;
    assign valid_out   = vld_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then random traffic checked every cycle against a word-level model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset, instr_valid, stall, wb_en;
    logic [15:0] instr, wb_data;
    logic [2:0]  wb_addr;
    logic        instr_ready;
    logic [15:0] Op1, Op2;
    logic [1:0]  ALUmode, carrySelect;
    logic [2:0]  Rdst_out;
    logic        wb_en_out, valid_out;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    decode_stage #(.NUM_REGS(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .instr_ready(instr_ready), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .Op1(Op1), .Op2(Op2),
        .ALUmode(ALUmode), .carrySelect(carrySelect), .Rdst_out(Rdst_out),
        .wb_en_out(wb_en_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // Reference model state: register contents, a pending first word, and the expected outputs.
    logic [15:0] mregs [8];
    bit          m_pending;
    logic [15:0] m_first;
    logic [15:0] m_op1, m_op2;
    logic [1:0]  m_alu, m_cs;
    logic [2:0]  m_rd;
    bit          m_wb, m_v, m_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mread(input logic [2:0] a);
        return (wb_en && wb_addr == a) ? wb_data : mregs[a];
    endfunction

    task automatic m_emit(input logic [15:0] w, input logic [15:0] imm);
        logic [4:0] opc;
        opc     = w[15:11];
        m_v     = 1; m_wb = 0; m_alu = 2'b11; m_cs = 2'b00;
        m_rd    = w[10:8]; m_op2 = 0; m_known = 1;
        case (opc)
            5'd3: begin m_op1 = mread(w[10:8]); m_alu = 2'b01; m_wb = 1; end
            5'd4: begin m_op1 = mread(w[7:5]); m_alu = 2'b10; m_wb = 1; end
            5'd5: begin m_op1 = mread(w[7:5]); m_op2 = mread(w[4:2]); m_alu = 2'b00; m_cs = 2'b10; m_wb = 1; end
            5'd6: begin m_op1 = mread(w[7:5]); m_op2 = imm; m_alu = 2'b00; m_cs = 2'b10; m_wb = 1; end
            5'd7: begin m_op1 = imm; m_alu = 2'b10; m_wb = 1; end
            5'd1: begin m_cs = 2'b01; m_known = 0; end
            5'd2: begin m_cs = 2'b11; m_known = 0; end
            default: m_known = 0;  // operand values of non-operand ops are left open
        endcase
    endtask

    task automatic m_bubble();
        m_v = 0; m_wb = 0; m_alu = 2'b11; m_cs = 2'b00;
    endtask

    task automatic m_step();
        if (reset) begin
            for (int i = 0; i < 8; i++) mregs[i] = 0;
            m_pending = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_known = 1;
            m_bubble();
        end else begin
            if (!stall) begin
                if (!instr_valid) m_bubble();
                else if (m_pending) begin m_emit(m_first, instr); m_pending = 0; end
                else if (instr[15:11] == 5'd6 || instr[15:11] == 5'd7) begin
                    m_first = instr; m_pending = 1; m_bubble();
                end else m_emit(instr, 16'h0);
            end
            if (wb_en) mregs[wb_addr] = wb_data;
        end
    endtask

    always @(posedge clk) begin
        if (run) begin
            m_step();
            #1;
            chk("valid_out", valid_out, m_v);
            chk("wb_en_out", wb_en_out, m_wb);
            chk("ALUmode", ALUmode, m_alu);
            chk("carrySelect", carrySelect, m_cs);
            chk("instr_ready", instr_ready, !stall);
            if (m_known) begin
                chk("Op1", Op1, m_op1);
                chk("Op2", Op2, m_op2);
                chk("Rdst_out", Rdst_out, m_rd);
            end
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [15:0] w, input bit st,
                       input bit we, input logic [2:0] wa, input logic [15:0] wd);
        @(negedge clk);
        reset = r; instr_valid = v; instr = w; stall = st;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1; instr_valid = 0; instr = 0; stall = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        @(negedge clk);
        run = 1;
        cyc(1, 0, 16'h0, 0, 0, 0, 0);
        after_edge();
        chk("rst_Op1", Op1, 16'h0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_ALUmode", ALUmode, 2'b11);

        // ADD R3,R1,R2 with R1=15, R2=24
        cyc(0, 0, 16'h0, 0, 1, 3'd1, 16'd15);
        cyc(0, 0, 16'h0, 0, 1, 3'd2, 16'd24);
        cyc(0, 1, 16'h2B28, 0, 0, 0, 0);
        after_edge();
        chk("add_Op1", Op1, 16'd15);
        chk("add_Op2", Op2, 16'd24);
        chk("add_ALUmode", ALUmode, 2'b00);
        chk("add_carrySel", carrySelect, 2'b10);
        chk("add_Rdst", Rdst_out, 3'd3);
        chk("add_wb", wb_en_out, 1'b1);

        // LDM R4, 0x002A
        cyc(0, 1, 16'h3C00, 0, 0, 0, 0);
        after_edge();
        chk("ldm_bubble", valid_out, 1'b0);
        cyc(0, 1, 16'h002A, 0, 0, 0, 0);
        after_edge();
        chk("ldm_Op1", Op1, 16'h002A);
        chk("ldm_ALUmode", ALUmode, 2'b10);
        chk("ldm_Rdst", Rdst_out, 3'd4);
        chk("ldm_valid", valid_out, 1'b1);

        // IADD R5,R1,7 with R1=100 written as the immediate is accepted
        cyc(0, 1, 16'h3520, 0, 0, 0, 0);
        cyc(0, 1, 16'd7, 0, 1, 3'd1, 16'd100);
        after_edge();
        chk("iadd_Op1_bypass", Op1, 16'd100);
        chk("iadd_Op2", Op2, 16'd7);

        // NOT R2 held off by stall, then released
        cyc(0, 1, 16'h1A00, 1, 0, 0, 0);
        #1;
        chk("stall_ready", instr_ready, 1'b0);
        after_edge();
        chk("stall_Op1_frozen", Op1, 16'd100);
        chk("stall_valid_frozen", valid_out, 1'b1);
        chk("stall_ALU_frozen", ALUmode, 2'b00);
        cyc(0, 1, 16'h1A00, 0, 0, 0, 0);
        after_edge();
        chk("not_Op1", Op1, 16'd24);
        chk("not_ALUmode", ALUmode, 2'b01);

        // SETC, CLRC, undefined opcode
        cyc(0, 1, 16'h0800, 0, 0, 0, 0);
        after_edge();
        chk("setc_cs", carrySelect, 2'b01);
        cyc(0, 1, 16'h1000, 0, 0, 0, 0);
        after_edge();
        chk("clrc_cs", carrySelect, 2'b11);
        cyc(0, 1, 16'hF800, 0, 0, 0, 0);
        after_edge();
        chk("undef_ALUmode", ALUmode, 2'b11);
        chk("undef_valid", valid_out, 1'b1);
        chk("undef_cs", carrySelect, 2'b00);

        // Reset between LDM's two words
        cyc(0, 1, 16'h3C00, 0, 0, 0, 0);
        cyc(1, 1, 16'h1234, 1, 0, 0, 0);
        after_edge();
        chk("midrst_Op1", Op1, 16'h0);
        chk("midrst_Op2", Op2, 16'h0);
        chk("midrst_Rdst", Rdst_out, 3'd0);
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_ALU", ALUmode, 2'b11);
        cyc(0, 1, 16'h0800, 0, 0, 0, 0);
        after_edge();
        chk("postrst_opcode_cs", carrySelect, 2'b01);
        chk("postrst_opcode_ALU", ALUmode, 2'b11);
        chk("postrst_opcode_valid", valid_out, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  opc;
            logic [15:0] w;
            int sel;
            sel = $urandom_range(0, 11);
            opc = (sel < 8) ? sel[4:0] : ((sel == 11) ? 5'd31 : 5'($urandom_range(8, 30)));
            w   = {opc, 11'($urandom)};
            if ($urandom_range(0, 3) == 0) w = 16'($urandom);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), w,
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 9) < 4),
                3'($urandom), 16'($urandom));
        end
        cyc(0, 0, 16'h0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
